// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a byte-addressable on-chip SRAM.
// Configurable bus width and wait states. Byte-lane writes are derived
// from HADDR/HSIZE. Illegal transfers get a two-cycle ERROR response.
// A read that directly follows a write to the same word sees the new data.
module ahb_sram_subordinate #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LB    = $clog2(NB);
   localparam int WA    = ADDR_WIDTH - LB;
   localparam int DEPTH = 1 << WA;
   localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [WA-1:0]         waddr_q;
   logic                  write_q;
   logic [NB-1:0]         mask_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  rdy_int;
   logic                  acc;
   logic                  legal;
   logic                  commit;
   logic [NB-1:0]         mask_a;
   logic [LB-1:0]         off;
   logic [WA-1:0]         waddr_a;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_htrans0;

   // HTRANS[0] only distinguishes SEQ from NONSEQ (or BUSY from IDLE),
   // and neither distinction matters to this memory.
   assign unused_htrans0 = HTRANS[0];

   assign off     = HADDR[LB-1:0];
   assign waddr_a = HADDR[ADDR_WIDTH-1:LB];
   // Only states that complete a data phase may accept a new address phase.
   assign acc     = HSEL & HTRANS[1] & HREADY & rdy_int;
   assign commit  = (state_q == S_LAST) & write_q;

   // Legality and lane mask of the transfer presented in the address phase.
   always_comb begin
      legal  = 1'b1;
      mask_a = '0;
      if (int'(HSIZE) > LB) begin
         legal = 1'b0;
      end else begin
         if ((int'(off) & ((1 << HSIZE) - 1)) != 0) legal = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (i >= int'(off) && i < int'(off) + (1 << HSIZE)) mask_a[i] = 1'b1;
         end
      end
   end

   // Word read for the new address phase. Lanes being committed on this
   // same edge are forwarded from HWDATA.
   always_comb begin
      rd_word = mem[waddr_a];
      if (commit && (waddr_q == waddr_a)) begin
         for (int i = 0; i < NB; i++) begin
            if (mask_q[i]) rd_word[i*8 +: 8] = HWDATA[i*8 +: 8];
         end
      end
   end

   // Next state and wait-state counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_LAST;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            // IDLE, LAST and ERR2 all complete here. Accept the next transfer with no bubble.
            state_d = S_IDLE;
            if (acc) begin
               if (!legal) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = S_LAST;
               end
            end
         end
      endcase
   end

   // Response outputs decoded from state.
   always_comb begin
      rdy_int = !((state_q == S_WAIT) || (state_q == S_ERR1));
      HRESP   = (state_q == S_ERR1) || (state_q == S_ERR2);
   end

   assign HREADYOUT = rdy_int;
   assign HRDATA    = rdata_q;

   // State register and data-phase capture of the accepted transfer.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         waddr_q <= '0;
         write_q <= 1'b0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (acc) begin
            waddr_q <= waddr_a;
            write_q <= HWRITE & legal;
            mask_q  <= mask_a;
            if (legal && !HWRITE) rdata_q <= rd_word;
         end
      end
   end

   // Memory array: masked lane write at the end of the LAST cycle. A reset
   // on that edge drops the write. Contents are never cleared.
   always_ff @(posedge HCLK) begin
      if (HRESETn && commit) begin
         for (int i = 0; i < NB; i++) begin
            if (mask_q[i]) mem[waddr_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate. Four instances cover the
// configurations: 32b/0ws, 32b/3ws, 32b/2ws, 64b/0ws. One shared bus drives
// them, and sel routes HSEL to one instance and its responses back.
module tb_ahb_sram_subordinate;

   typedef struct {
      int          sel;
      logic        wr;
      logic [11:0] addr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        resp;
      logic        chk;
   } vec_t;

   logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, hold = 1'b0;
   logic [11:0] HADDR = '0;
   logic [2:0]  HSIZE = '0;
   logic [1:0]  HTRANS = '0;
   logic [63:0] HWDATA = '0;
   int          sel = 0;

   logic [3:0]  hsel_k, rdy, resp;
   logic [31:0] rd0, rd1, rd2;
   logic [63:0] rd3, m_rd;
   logic        m_rdy, m_resp, HREADY;

   int ws [4] = '{0, 3, 2, 0};
   int checks = 0, errors = 0;

   vec_t vt [$];
   vec_t sb [$];
   vec_t cur;
   bit   in_dp = 0, rd_bad = 0, resp_bad = 0;
   int   dp_cyc = 0;

   always #5 HCLK = ~HCLK;

   always_comb begin
      for (int k = 0; k < 4; k++) hsel_k[k] = HSEL && (sel == k);
      case (sel)
         1:       m_rd = {32'b0, rd1};
         2:       m_rd = {32'b0, rd2};
         3:       m_rd = rd3;
         default: m_rd = {32'b0, rd0};
      endcase
      m_rdy  = rdy[sel];
      m_resp = resp[sel];
      HREADY = m_rdy & ~hold;
   end

   ahb_sram_subordinate #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[0]), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA[31:0]),
      .HRDATA(rd0), .HREADYOUT(rdy[0]), .HRESP(resp[0]));
   ahb_sram_subordinate #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3)) u1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[1]), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA[31:0]),
      .HRDATA(rd1), .HREADYOUT(rdy[1]), .HRESP(resp[1]));
   ahb_sram_subordinate #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(2)) u2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[2]), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA[31:0]),
      .HRDATA(rd2), .HREADYOUT(rdy[2]), .HRESP(resp[2]));
   ahb_sram_subordinate #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .WAIT_STATES(0)) u3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[3]), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
      .HRDATA(rd3), .HREADYOUT(rdy[3]), .HRESP(resp[3]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(int s, logic w, logic [11:0] a, logic [2:0] z,
                               logic [63:0] wd, logic [63:0] rd, logic rs, logic c);
      vec_t v;
      v.sel = s; v.wr = w; v.addr = a; v.size = z;
      v.wdata = wd; v.rdata = rd; v.resp = rs; v.chk = c;
      return v;
   endfunction

   // Scoreboard side. Sample away from the rising edge. Pop an entry when an
   // address phase is accepted. Check every data-phase cycle, and finish the
   // checks when the phase completes.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         in_dp = 0;
      end else begin
         if (in_dp) begin
            dp_cyc++;
            if (cur.chk && (m_rd !== cur.rdata)) rd_bad = 1;
            if (!m_rdy && (m_resp !== cur.resp)) resp_bad = 1;
            if (m_rdy) begin
               chk("resp", {63'b0, m_resp}, {63'b0, cur.resp});
               chk("resp_early_cycles", {63'b0, resp_bad}, 64'd0);
               chk("phase_len", 64'(dp_cyc), cur.resp ? 64'd2 : 64'(ws[cur.sel] + 1));
               if (cur.chk) begin
                  chk("rdata", m_rd, cur.rdata);
                  chk("rdata_stable", {63'b0, rd_bad}, 64'd0);
               end
               in_dp = 0;
            end
         end
         if (HSEL && HTRANS[1] && HREADY) begin
            if (sb.size() == 0) begin
               chk("unexpected_accept", 64'd1, 64'd0);
            end else begin
               cur = sb.pop_front();
               in_dp = 1; dp_cyc = 0; rd_bad = 0; resp_bad = 0;
            end
         end
      end
   end

   // Address phase: push the expectation, hold the request until accepted,
   // then present write data for the data phase.
   task automatic drive(input vec_t v);
      int  n = 0;
      logic r;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = v.wr; HADDR = v.addr; HSIZE = v.size;
      sb.push_back(v);
      do begin
         @(negedge HCLK); r = HREADY;
         @(posedge HCLK); n++;
      end while (!r && n < 64);
      if (!r) chk("accept_timeout", 64'd1, 64'd0);
      #1;
      HWDATA = v.wdata;
      HSEL = 1'b0; HTRANS = 2'b00;
   endtask

   task automatic drain();
      int n = 0;
      HSEL = 1'b0; HTRANS = 2'b00;
      while ((sb.size() != 0 || in_dp) && n < 100) begin
         @(posedge HCLK); #1; n++;
      end
      if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      // 32-bit, no wait states
      vt.push_back(mk(0, 1, 12'h010, 3'd2, 64'hDEADBEEF, 0, 0, 0));
      vt.push_back(mk(0, 0, 12'h010, 3'd2, 0, 64'hDEADBEEF, 0, 1));
      vt.push_back(mk(0, 1, 12'h020, 3'd2, 64'h11223344, 0, 0, 0));
      vt.push_back(mk(0, 1, 12'h021, 3'd0, 64'h0000AA00, 0, 0, 0));
      vt.push_back(mk(0, 1, 12'h022, 3'd1, 64'hBBCC0000, 0, 0, 0));
      vt.push_back(mk(0, 0, 12'h020, 3'd2, 0, 64'hBBCCAA44, 0, 1));
      vt.push_back(mk(0, 1, 12'h040, 3'd2, 64'h00000000, 0, 0, 0));
      vt.push_back(mk(0, 1, 12'h043, 3'd0, 64'h5A000000, 0, 0, 0));
      vt.push_back(mk(0, 0, 12'h040, 3'd2, 0, 64'h5A000000, 0, 1));
      vt.push_back(mk(0, 1, 12'h000, 3'd2, 64'hCAFEF00D, 0, 0, 0));
      vt.push_back(mk(0, 1, 12'h002, 3'd2, 64'h12345678, 0, 1, 0));
      vt.push_back(mk(0, 1, 12'h000, 3'd3, 64'h87654321, 0, 1, 0));
      vt.push_back(mk(0, 0, 12'h000, 3'd2, 0, 64'hCAFEF00D, 0, 1));
      vt.push_back(mk(0, 0, 12'h012, 3'd1, 0, 64'hDEADBEEF, 0, 1));
      // 64-bit, no wait states
      vt.push_back(mk(3, 1, 12'h008, 3'd3, 64'h0123456789ABCDEF, 0, 0, 0));
      vt.push_back(mk(3, 0, 12'h008, 3'd3, 0, 64'h0123456789ABCDEF, 0, 1));
      vt.push_back(mk(3, 1, 12'h00C, 3'd2, 64'hA5A5A5A500000000, 0, 0, 0));
      vt.push_back(mk(3, 0, 12'h008, 3'd3, 0, 64'hA5A5A5A589ABCDEF, 0, 1));
      vt.push_back(mk(3, 1, 12'h004, 3'd3, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0));
      vt.push_back(mk(3, 0, 12'h008, 3'd3, 0, 64'hA5A5A5A589ABCDEF, 0, 1));
      // 32-bit, 3 wait states
      vt.push_back(mk(1, 1, 12'h100, 3'd2, 64'h01020304, 0, 0, 0));
      vt.push_back(mk(1, 0, 12'h100, 3'd2, 0, 64'h01020304, 0, 1));
      vt.push_back(mk(1, 1, 12'h101, 3'd2, 64'h99999999, 0, 1, 0));
      vt.push_back(mk(1, 0, 12'h100, 3'd2, 0, 64'h01020304, 0, 1));
      // 32-bit, 2 wait states
      vt.push_back(mk(2, 1, 12'h080, 3'd2, 64'h55667788, 0, 0, 0));
      vt.push_back(mk(2, 0, 12'h080, 3'd2, 0, 64'h55667788, 0, 1));

      // Reset held for two edges.
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_hreadyout_u0", {63'b0, rdy[0]}, 64'd1);
      chk("rst_hresp_u0", {63'b0, resp[0]}, 64'd0);
      chk("rst_hrdata_u0", {32'b0, rd0}, 64'd0);
      chk("rst_hreadyout_u3", {63'b0, rdy[3]}, 64'd1);
      chk("rst_hresp_u3", {63'b0, resp[3]}, 64'd0);
      chk("rst_hrdata_u3", rd3, 64'd0);
      HRESETn = 1'b1;

      sel = vt[0].sel;
      foreach (vt[i]) begin
         if (vt[i].sel != sel) begin
            drain();
            sel = vt[i].sel;
         end
         drive(vt[i]);
      end
      drain();

      // Another subordinate stalls: HREADY low must block acceptance.
      sel = 0; hold = 1'b1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 12'h020; HSIZE = 3'd2;
      repeat (2) @(posedge HCLK);
      #1;
      chk("stall_hreadyout", {63'b0, rdy[0]}, 64'd1);
      chk("stall_hrdata_held", {32'b0, rd0}, 64'hDEADBEEF);
      HSEL = 1'b0; HTRANS = 2'b00; hold = 1'b0;
      @(posedge HCLK); #1;

      // Reset during the first wait cycle of a write: the write is dropped.
      sel = 2;
      drive(mk(2, 1, 12'h080, 3'd2, 64'hFFFFFFFF, 0, 0, 0));
      chk("midrst_in_wait", {63'b0, rdy[2]}, 64'd0);
      HRESETn = 1'b0;
      @(posedge HCLK); #1;
      chk("midrst_hreadyout", {63'b0, rdy[2]}, 64'd1);
      chk("midrst_hresp", {63'b0, resp[2]}, 64'd0);
      chk("midrst_hrdata", {32'b0, rd2}, 64'd0);
      HRESETn = 1'b1;
      drive(mk(2, 0, 12'h080, 3'd2, 0, 64'h55667788, 0, 1));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

Parametrised AHB-Lite subordinate wrapping a byte-addressable on-chip SRAM, the next generation of the LSU data-memory subordinate. It adds configurable data width, programmable wait states, true byte-lane writes from HADDR/HSIZE, an AHB two-cycle ERROR response for illegal transfers, and read-after-write forwarding for back-to-back pipelined transfers. It sits on the bus behind the address decoder, which drives HSEL.

## Interface
- ADDR_WIDTH, 12: byte-address width; memory holds 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32: bus width, 32 or 64; NB = DATA_WIDTH/8 lanes, LB = log2(NB).
- WAIT_STATES, 0: extra data-phase cycles per OKAY transfer, 0..7.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset; synchronous, active-low.
- HSEL  in  1  subordinate select.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size (2**HSIZE bytes).
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HREADY  in  1  bus ready (previous data phase completing).
- HWDATA  in  DATA_WIDTH  write data, valid in data phase.
- HRDATA  out  DATA_WIDTH  read data; full word at addressed location.
- HREADYOUT  out  1  data-phase completion.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept: HSEL & HTRANS[1] & HREADY at a rising edge latches addr, write, size into data-phase registers. IDLE/BUSY or HSEL=0: no access, zero-wait OKAY.
- Legality: error if HSIZE > LB, or HADDR[LB-1:0] not a multiple of 2**HSIZE. Illegal transfer never touches memory.
- Lane mask: ((1 << 2**HSIZE) - 1) << HADDR[LB-1:0], NB bits.
- State machine: IDLE -> WAIT (legal, WAIT_STATES>0) -> LAST; IDLE -> LAST (legal, WAIT_STATES=0); IDLE -> ERR1 -> ERR2 (illegal). LAST/ERR2 return to IDLE, or re-enter immediately if a new transfer is accepted in the same cycle.
- WAIT: down-counter loaded with WAIT_STATES-1; HREADYOUT=0, HRESP=0; go to LAST at 0.
- LAST: HREADYOUT=1, HRESP=0; a write commits masked HWDATA lanes at the end of this cycle.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Wait states not applied to errors.
- Read: word read into an HRDATA register at acceptance; held stable through the whole data phase.
- Forwarding: if a read is accepted on the same edge a write commits to the same word, the HRDATA register gets the written lanes from HWDATA and the other lanes from memory.
- Outside the data phase HRDATA holds its last value.

## Timing
- Reset (HRESETn=0 at an edge): state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0. A pending write is dropped. Memory contents are not reset.
- OKAY latency: data phase is WAIT_STATES+1 cycles after the accepting edge.
- ERROR: exactly 2 data-phase cycles.
- Back-to-back: a new address phase overlapping LAST/ERR2 is accepted with no bubble.
- A transfer accepted during ERR2 (manager did not cancel) is processed normally.
- HREADY low while HREADYOUT high (another subordinate stalling): no acceptance, no state change.

## Test plan
- Reset, WAIT_STATES=0: hold HRESETn=0 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0. Then write word 0xDEADBEEF @0x010 followed by a read @0x010 -> read data phase returns 0xDEADBEEF, no stall cycles.
- Byte lanes, DATA_WIDTH=32: write word 0x11223344 @0x20. Then write byte 0xAA @0x21 and halfword 0xBBCC @0x22. Read @0x20 -> 0xBBCCAA44.
- Forwarding: word @0x40=0; pipelined write byte 0x5A @0x43 immediately followed by read @0x40 -> HRDATA=0x5A000000 in the read's data phase.
- Wait states, WAIT_STATES=3: read -> HREADYOUT low exactly 3 cycles then high with valid data; HRDATA stable across all 4 cycles.
- Errors: word write @0x002, and HSIZE=3 on a 32-bit bus -> each gives ERR1 (HREADYOUT=0/HRESP=1) then ERR2 (1/1); memory unchanged on readback. Repeat on a 64-bit bus: HSIZE=3 @0x008 is OKAY.
- Reset mid-operation, WAIT_STATES=2: write accepted, HRESETn low during the first WAIT cycle -> next cycle HREADYOUT=1, HRESP=0; readback shows old data.
